// File: rtl/md_dump.sv
// md_dump: streams per-cell position cache contents to the host as AXI-Stream beats
module md_dump #(
  parameter int NUM_CELLS         = 8,
  parameter int NUM_SUB_PACKETS   = 4,
  parameter int SUB_PACKET_WIDTH  = 128,
  parameter int OFFSET_WIDTH      = 27,
  parameter int ELEMENT_WIDTH     = 2,
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int RD_LATENCY        = 2,
  parameter int FIFO_DEPTH        = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      i_dump_start,
  input  logic [PARTICLE_ID_WIDTH-1:0]              i_dump_num_particles,
  output logic                                      o_dump_rd_en,
  output logic [PARTICLE_ID_WIDTH-1:0]              o_dump_rd_addr,
  input  logic [NUM_CELLS*3*OFFSET_WIDTH-1:0]       i_dump_data,
  input  logic [NUM_CELLS*ELEMENT_WIDTH-1:0]        i_dump_element,
  output logic [NUM_SUB_PACKETS*SUB_PACKET_WIDTH-1:0] o_dump_tdata,
  output logic                                      o_dump_tvalid,
  input  logic                                      i_dump_tready,
  output logic                                      o_dump_tlast,
  output logic                                      o_dump_busy,
  output logic                                      o_dump_done
);
  localparam int NUM_DUMP_STEPS = NUM_CELLS / NUM_SUB_PACKETS;
  localparam int AXW = NUM_SUB_PACKETS * SUB_PACKET_WIDTH;
  localparam int OSW = 3 * OFFSET_WIDTH;
  localparam int STEP_W = NUM_DUMP_STEPS > 1 ? $clog2(NUM_DUMP_STEPS) : 1;
  localparam int PTR_W = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + RD_LATENCY + 1);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [PARTICLE_ID_WIDTH-1:0] n_q, n_d, addr_q, addr_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [RD_LATENCY-1:0] pv_q, pl_q;
  logic [STEP_W-1:0] ps_q [RD_LATENCY];
  logic [AXW:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q, inflight;
  logic rd_en, push, pop, last_addr, last_step, drain_ok;
  logic [AXW-1:0] beat;
  always_comb begin
    inflight = '0;
    for (int k = 0; k < RD_LATENCY; k++) inflight = inflight + CW'(pv_q[k]);
  end
  assign rd_en = state_q == READ && (inflight + cnt_q) < CW'(FIFO_DEPTH);
  assign last_addr = addr_q == n_q - 1'b1;
  assign last_step = step_q == STEP_W'(NUM_DUMP_STEPS - 1);
  assign push = pv_q[RD_LATENCY-1];
  assign o_dump_tvalid = cnt_q != '0;
  assign pop = o_dump_tvalid && i_dump_tready;
  assign drain_ok = inflight == '0 && cnt_q - CW'(pop) == '0;
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    addr_d = addr_q;
    step_d = step_q;
    case (state_q)
      IDLE: if (i_dump_start) begin
        n_d = i_dump_num_particles;
        addr_d = '0;
        step_d = '0;
        state_d = i_dump_num_particles == '0 ? DONE : READ;
      end
      READ: if (rd_en) begin
        addr_d = last_addr ? '0 : addr_q + 1'b1;
        step_d = last_addr && !last_step ? step_q + 1'b1 : step_q;
        state_d = last_addr && last_step ? DRAIN : READ;
      end
      DRAIN: state_d = drain_ok ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q <= '0;
      addr_q <= '0;
      step_q <= '0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      addr_q <= addr_d;
      step_q <= step_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pv_q <= '0;
      pl_q <= '0;
      for (int k = 0; k < RD_LATENCY; k++) ps_q[k] <= '0;
    end else begin
      for (int k = RD_LATENCY - 1; k > 0; k--) begin
        pv_q[k] <= pv_q[k-1];
        pl_q[k] <= pl_q[k-1];
        ps_q[k] <= ps_q[k-1];
      end
      pv_q[0] <= rd_en;
      pl_q[0] <= rd_en && last_addr && last_step;
      ps_q[0] <= step_q;
    end
  end
  always_comb begin
    beat = '0;
    for (int i = 0; i < NUM_SUB_PACKETS; i++) begin
      beat[i*SUB_PACKET_WIDTH +: OFFSET_WIDTH] = i_dump_data[(int'(ps_q[RD_LATENCY-1])*NUM_SUB_PACKETS+i)*OSW +: OFFSET_WIDTH];
      beat[i*SUB_PACKET_WIDTH+32 +: OFFSET_WIDTH] = i_dump_data[(int'(ps_q[RD_LATENCY-1])*NUM_SUB_PACKETS+i)*OSW+OFFSET_WIDTH +: OFFSET_WIDTH];
      beat[i*SUB_PACKET_WIDTH+64 +: OFFSET_WIDTH] = i_dump_data[(int'(ps_q[RD_LATENCY-1])*NUM_SUB_PACKETS+i)*OSW+2*OFFSET_WIDTH +: OFFSET_WIDTH];
      beat[i*SUB_PACKET_WIDTH+96 +: ELEMENT_WIDTH] = i_dump_element[(int'(ps_q[RD_LATENCY-1])*NUM_SUB_PACKETS+i)*ELEMENT_WIDTH +: ELEMENT_WIDTH];
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wp_q] <= {pl_q[RD_LATENCY-1], beat};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q == PTR_W'(FIFO_DEPTH - 1) ? '0 : wp_q + 1'b1;
      if (pop) rp_q <= rp_q == PTR_W'(FIFO_DEPTH - 1) ? '0 : rp_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end
  assign o_dump_rd_en = rd_en;
  assign o_dump_rd_addr = addr_q;
  assign o_dump_tdata = o_dump_tvalid ? mem[rp_q][AXW-1:0] : '0;
  assign o_dump_tlast = o_dump_tvalid && mem[rp_q][AXW];
  assign o_dump_busy = state_q != IDLE;
  assign o_dump_done = state_q == DONE;
endmodule

// File: tb/tb_md_dump.sv
// tb_md_dump: directed self-checking bench for md_dump
module tb_md_dump;
  logic clk = 1'b0;
  logic rst, dump_start, rd_en, tvalid, tready, tlast, busy, done;
  logic [6:0] num, rd_addr, a1, a2;
  logic [647:0] dump_data;
  logic [15:0] dump_el;
  logic [511:0] tdata, pad;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  md_dump dut (
    .clk(clk), .rst(rst), .i_dump_start(dump_start), .i_dump_num_particles(num),
    .o_dump_rd_en(rd_en), .o_dump_rd_addr(rd_addr), .i_dump_data(dump_data),
    .i_dump_element(dump_el), .o_dump_tdata(tdata), .o_dump_tvalid(tvalid),
    .i_dump_tready(tready), .o_dump_tlast(tlast), .o_dump_busy(busy), .o_dump_done(done)
  );
  always @(posedge clk) begin
    a1 <= rd_addr;
    a2 <= a1;
  end
  always_comb begin
    dump_data = '0;
    dump_el = '0;
    for (int c = 0; c < 8; c++) begin
      dump_data[c*81 +: 27] = 27'(100*c + int'(a2));
      dump_data[c*81+27 +: 27] = 27'(100*c + int'(a2) + 1);
      dump_data[c*81+54 +: 27] = 27'(100*c + int'(a2) + 2);
      dump_el[c*2 +: 2] = 2'(c);
    end
  end
  function automatic logic [511:0] exp_beat(int s, int a);
    logic [511:0] w = '0;
    for (int i = 0; i < 4; i++) begin
      w[i*128 +: 27] = 27'(100*(s*4+i) + a);
      w[i*128+32 +: 27] = 27'(100*(s*4+i) + a + 1);
      w[i*128+64 +: 27] = 27'(100*(s*4+i) + a + 2);
      w[i*128+96 +: 2] = 2'((s*4+i) & 3);
    end
    return w;
  endfunction
  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chki(input string tag, input integer obs, input integer exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic run_dump(input int n, input int rmode, input int inj);
    int cyc, issued, acc, first_v, done_cyc, last_hs, cred_bad, stall_bad, busy_bad, max_out, total;
    logic [511:0] prev;
    logic prev_stall;
    total = n * 2;
    issued = 0; acc = 0; first_v = -1; done_cyc = -1; last_hs = -1;
    cred_bad = 0; stall_bad = 0; busy_bad = 0; max_out = 0; prev_stall = 1'b0; prev = '0;
    dump_start = 1'b1;
    num = 7'(n);
    @(posedge clk); #1;
    dump_start = 1'b0;
    num = 7'd5;
    cyc = 1;
    chki("first_rd_en", 32'(rd_en), n != 0);
    while (cyc < 400 && done_cyc < 0) begin
      if (rd_en) begin
        if (issued - acc >= 8) cred_bad++;
        issued++;
        if (issued - acc > max_out) max_out = issued - acc;
      end
      if (tvalid && first_v < 0) first_v = cyc;
      if (prev_stall && (tdata !== prev || tvalid !== 1'b1)) stall_bad++;
      if (busy !== 1'b1) busy_bad++;
      if (done) done_cyc = cyc;
      tready = rmode == 0 ? 1'b1 : (cyc % 4 == 0);
      dump_start = inj != 0 && cyc == inj;
      if (tvalid && tready) begin
        chk("beat", tdata, exp_beat(acc / n, acc % n));
        chk("padding", tdata & pad, '0);
        chki("tlast", 32'(tlast), acc == total - 1);
        if (n == 3 && acc == 4) begin
          chki("b5_x", 32'(tdata[128 +: 27]), 501);
          chki("b5_y", 32'(tdata[160 +: 27]), 502);
          chki("b5_z", 32'(tdata[192 +: 27]), 503);
          chki("b5_el", 32'(tdata[224 +: 2]), 1);
        end
        if (acc == total - 1) last_hs = cyc;
        acc++;
      end
      prev_stall = tvalid && !tready;
      prev = tdata;
      @(posedge clk); #1;
      cyc++;
    end
    dump_start = 1'b0;
    tready = 1'b1;
    chki("done_cycle", done_cyc, n == 0 ? 1 : last_hs + 1);
    chki("beats", acc, total);
    chki("reads", issued, total);
    chki("credit_limit", cred_bad, 0);
    chki("stall_stable", stall_bad, 0);
    chki("busy_during", busy_bad, 0);
    if (rmode == 0 && n != 0) begin
      chki("first_tvalid", first_v, 4);
      chki("throughput", last_hs - first_v, total - 1);
    end
    if (rmode == 1 && n == 10) chki("credit_max", max_out, 8);
    @(posedge clk); #1;
    chki("busy_after", 32'(busy), 0);
    chki("done_after", 32'(done), 0);
  endtask
  initial begin
    int acc, cyc;
    pad = '0;
    for (int i = 0; i < 4; i++)
      for (int b = 0; b < 128; b++)
        pad[i*128+b] = (b >= 27 && b < 32) || (b >= 59 && b < 64) || (b >= 91 && b < 96) || b >= 98;
    rst = 1'b1; dump_start = 1'b0; num = '0; tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chki("rst_rd_en", 32'(rd_en), 0);
    chki("rst_rd_addr", 32'(rd_addr), 0);
    chki("rst_tvalid", 32'(tvalid), 0);
    chki("rst_tlast", 32'(tlast), 0);
    chk("rst_tdata", tdata, '0);
    chki("rst_busy", 32'(busy), 0);
    chki("rst_done", 32'(done), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_dump(3, 0, 0);
    run_dump(3, 1, 0);
    run_dump(0, 0, 0);
    run_dump(3, 0, 5);
    run_dump(10, 1, 0);
    run_dump(10, 0, 0);
    dump_start = 1'b1;
    num = 7'd3;
    @(posedge clk); #1;
    dump_start = 1'b0;
    acc = 0;
    cyc = 0;
    while (acc < 2 && cyc < 50) begin
      if (tvalid && tready) acc++;
      @(posedge clk); #1;
      cyc++;
    end
    chki("rst_mid_reach", acc, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    chki("rst_mid_tvalid", 32'(tvalid), 0);
    chki("rst_mid_busy", 32'(busy), 0);
    chki("rst_mid_rd_en", 32'(rd_en), 0);
    rst = 1'b0;
    run_dump(3, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
